stream_sum_int: RTL and testbench

STREAM_SUM_INT -- requirements
Module: stream_sum_int

---
 rtl/stream_sum_int.sv | 116 +++++++++++
 tb/tb_stream_sum_int.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sum_int.sv
// stream_sum_int: accepts a job carrying an element count N, sums the next N
// stream elements (wrapping at 2^intN) and offers the sum on the output
// channel until the consumer takes it.
//
// Handshake rule for all three channels (job, stream, result): a beat moves
// only on a rising clk edge where that channel's valid and ready are both 1.
// Ready/valid outputs never depend on the partner's valid/ready in the same
// cycle. They come from registers and are forced low while rst is high, so
// nothing can move during reset.
module stream_sum_int #(
    parameter int intN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [intN-1:0] dIn,
    input  logic [intN-1:0] sIn,
    input  logic            sIn_valid,
    output logic            sIn_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [intN-1:0] dOut,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONSUME = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_q;
    logic [intN-1:0] acc_q;
    logic [intN-1:0] rem_q;
    logic            in_ready_q;
    logic            sIn_ready_q;
    logic            out_valid_q;

    logic [intN-1:0] acc_d;
    logic [intN-1:0] rem_d;
    logic            job_fire;
    logic            beat_fire;
    logic            res_fire;

    // Datapath next values and channel transfer strobes.
    always_comb begin
        acc_d     = acc_q + sIn;
        rem_d     = rem_q - intN'(1);
        job_fire  = in_valid & in_ready_q;
        beat_fire = sIn_valid & sIn_ready_q;
        res_fire  = out_ready & out_valid_q;
    end

    // Control FSM with registered handshake outputs and the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;  // masked by rst below; visible once rst drops
            sIn_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_fire) begin
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (dIn == '0) begin
                            // Empty job: the result (zero) is ready at once.
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            rem_q       <= dIn;
                            state_q     <= CONSUME;
                            sIn_ready_q <= 1'b1;
                        end
                    end
                end
                CONSUME: begin
                    if (beat_fire) begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        if (rem_q == intN'(1)) begin
                            state_q     <= DONE;
                            sIn_ready_q <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // No job is taken in the same cycle the result leaves.
                    if (res_fire) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    sIn_ready_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q & ~rst;
    assign sIn_ready = sIn_ready_q & ~rst;
    assign out_valid = out_valid_q & ~rst;
    assign dOut      = acc_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_stream_sum_int.sv
// tb_stream_sum_int: directed and randomized jobs for stream_sum_int,
// checked against a job-level reference (sum of the elements mod 256).
module tb_stream_sum_int;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dIn;
    logic [7:0] sIn;
    logic       sIn_valid;
    logic       sIn_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dOut;
    logic [1:0] state_dbg;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_xfer = 0;
    int n_beats = 0;
    int exp_beats = 0;
    logic [7:0] exp_q[$];
    int elem_q[$];          // directed elements; -1 means a stall cycle
    logic [7:0] last_sum;
    bit gate_hold = 1'b0;   // hold sIn_valid high outside CONSUME

    stream_sum_int #(.intN(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .dIn(dIn),
        .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready),
        .out_valid(out_valid), .out_ready(out_ready), .dOut(dOut),
        .state_o(state_dbg)
    );

    // Clock and a hard time limit.
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    // Monitor: result transfers are scored against the expected queue.
    always @(negedge clk) begin
        if (!rst && sIn_valid && sIn_ready) n_beats++;
        if (!rst && out_valid && out_ready) begin
            n_xfer++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL result_xfer: unexpected result got %0d required none", dOut);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dOut !== e) begin
                    n_bad++;
                    $display("FAIL result_xfer: got %0d required %0d", dOut, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic junk_valid();
        return gate_hold ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // One complete job: optional idle cycles, accept, beats, result with
    // bp cycles of backpressure. Elements come from elem_q, else random.
    task automatic run_job(input int n, input int bp, input int idle);
        int sum_exp;
        int consumed;
        int guard;
        int v;
        logic [7:0] exp8;
        out_ready = (bp == 0);
        for (int i = 0; i < idle; i++) begin
            sIn_valid = junk_valid();
            sIn = 8'($urandom);
            #1;
            n_cmp++;
            if ({in_ready, sIn_ready, out_valid} !== 3'b100 || dOut !== last_sum) begin
                n_bad++;
                $display("FAIL idle: got rdy/srdy/ov=%b dOut=%0d required 100 dOut=%0d",
                         {in_ready, sIn_ready, out_valid}, dOut, last_sum);
            end
            tick();
        end
        in_valid = 1'b1;
        dIn = 8'(n);
        sIn_valid = junk_valid();
        sIn = 8'($urandom);
        #1;
        n_cmp++;
        if ({in_ready, sIn_ready, out_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL accept: got rdy/srdy/ov=%b required 100", {in_ready, sIn_ready, out_valid});
        end
        tick();
        in_valid = 1'b0;
        dIn = 8'($urandom);  // must not affect the running job
        sum_exp = 0;
        consumed = 0;
        guard = 0;
        while (consumed < n && guard < 500) begin
            n_cmp++;
            if ({in_ready, sIn_ready, out_valid} !== 3'b010 || dOut !== 8'(sum_exp % 256)) begin
                n_bad++;
                $display("FAIL consume: got rdy/srdy/ov=%b dOut=%0d required 010 dOut=%0d",
                         {in_ready, sIn_ready, out_valid}, dOut, sum_exp % 256);
            end
            if (elem_q.size() > 0) v = elem_q.pop_front();
            else v = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 255));
            if (v < 0) begin
                sIn_valid = 1'b0;
                sIn = 8'($urandom);
            end else begin
                sIn_valid = 1'b1;
                sIn = 8'(v);
                sum_exp += v;
                consumed++;
                exp_beats++;
            end
            tick();
            guard++;
        end
        n_cmp++;
        if (consumed != n) begin
            n_bad++;
            $display("FAIL consume_bound: got %0d beats required %0d", consumed, n);
        end
        exp8 = 8'(sum_exp % 256);
        exp_q.push_back(exp8);
        sIn_valid = junk_valid();
        sIn = 8'($urandom);
        for (int i = 0; i <= bp; i++) begin
            if (i == bp) out_ready = 1'b1;
            #1;
            n_cmp++;
            if ({in_ready, sIn_ready, out_valid} !== 3'b001 || dOut !== exp8) begin
                n_bad++;
                $display("FAIL done: got rdy/srdy/ov=%b dOut=%0d required 001 dOut=%0d",
                         {in_ready, sIn_ready, out_valid}, dOut, exp8);
            end
            tick();
        end
        n_cmp++;
        if ({in_ready, sIn_ready, out_valid} !== 3'b100 || dOut !== exp8) begin
            n_bad++;
            $display("FAIL after_result: got rdy/srdy/ov=%b dOut=%0d required 100 dOut=%0d",
                     {in_ready, sIn_ready, out_valid}, dOut, exp8);
        end
        last_sum = exp8;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        dIn = 8'd0;
        sIn = 8'hA5;
        sIn_valid = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({in_ready, sIn_ready, out_valid} !== 3'b000 || dOut !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got rdy/srdy/ov=%b dOut=%0d required 000 dOut=0",
                     {in_ready, sIn_ready, out_valid}, dOut);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, sIn_ready, out_valid} !== 3'b100 || dOut !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_release: got rdy/srdy/ov=%b dOut=%0d required 100 dOut=0",
                     {in_ready, sIn_ready, out_valid}, dOut);
        end
        last_sum = 8'd0;
    endtask

    task automatic test_basic;
        elem_q = '{5, 7, 9};
        run_job(3, 0, 0);
        n_cmp++;
        if (last_sum !== 8'd21) begin
            n_bad++;
            $display("FAIL basic_sum: got %0d required 21", last_sum);
        end
    endtask

    task automatic test_stall_backpressure;
        int x0;
        x0 = n_xfer;
        elem_q = '{10, -1, -1, -1, 20};
        run_job(2, 4, 1);
        n_cmp++;
        if (n_xfer - x0 != 1) begin
            n_bad++;
            $display("FAIL stall_xfers: got %0d transfers required 1", n_xfer - x0);
        end
    endtask

    task automatic test_zero_count;
        int b0;
        b0 = n_beats;
        gate_hold = 1'b1;
        run_job(0, 1, 1);
        gate_hold = 1'b0;
        n_cmp++;
        if (n_beats != b0) begin
            n_bad++;
            $display("FAIL zero_beats: got %0d beats required 0", n_beats - b0);
        end
    endtask

    task automatic test_wrap;
        elem_q = '{200, 100};
        run_job(2, 0, 0);
        n_cmp++;
        if (last_sum !== 8'd44) begin
            n_bad++;
            $display("FAIL wrap_sum: got %0d required 44", last_sum);
        end
    endtask

    task automatic test_mid_reset;
        int x0;
        x0 = n_xfer;
        out_ready = 1'b1;
        in_valid = 1'b1;
        dIn = 8'd4;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sIn_valid = 1'b1;
            sIn = 8'(11 + i);
            exp_beats++;
            tick();
        end
        rst = 1'b1;
        sIn = 8'd99;
        #1;
        n_cmp++;
        if ({in_ready, sIn_ready, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_reset_hold: got rdy/srdy/ov=%b required 000", {in_ready, sIn_ready, out_valid});
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, sIn_ready, out_valid} !== 3'b100 || dOut !== 8'd0 || n_xfer != x0) begin
            n_bad++;
            $display("FAIL mid_reset_release: got rdy/srdy/ov=%b dOut=%0d xfers=%0d required 100 dOut=0 xfers=0",
                     {in_ready, sIn_ready, out_valid}, dOut, n_xfer - x0);
        end
        last_sum = 8'd0;
        elem_q = '{42};
        run_job(1, 0, 0);
        n_cmp++;
        if (last_sum !== 8'd42) begin
            n_bad++;
            $display("FAIL mid_reset_newjob: got %0d required 42", last_sum);
        end
    endtask

    task automatic test_gating;
        gate_hold = 1'b1;
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(1, 3));
        gate_hold = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int j = 0; j < 30; j++)
            run_job($urandom_range(0, 8), $urandom_range(0, 2), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_backpressure();
        test_zero_count();
        test_wrap();
        test_mid_reset();
        test_gating();
        test_back_to_back();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_results: got %0d left required 0", exp_q.size());
        end
        n_cmp++;
        if (n_beats != exp_beats) begin
            n_bad++;
            $display("FAIL beat_count: got %0d required %0d", n_beats, exp_beats);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
